lru_eviction_policy: RTL and testbench
======================================

Name: lru_eviction_policy

Overview:
Replacement-policy engine on the consumer side of the way-lookup interface. It reads the hit/miss/hitWay results produced by the tag lookup and maintains true-LRU age state for a fully-associative set of NUM_WAYS ways. On a miss it selects a victim way, preferring invalid ways, and holds it for the cache controller until the fill is acknowledged.

Parameters:
NUM_WAYS, 4, number of ways; must be a power of 2 and at least 2.
WAY_IDX_W, $clog2(NUM_WAYS), width of the way index and of each age counter (derived; do not override).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
hit  in  1  lookup hit strobe, from the way-lookup interface.
miss  in  1  lookup miss strobe, from the way-lookup interface.
hitWay  in  NUM_WAYS  one-hot hit way; qualified by hit.
wayValid  in  NUM_WAYS  per-way valid bits from the tag store.
fillAck  in  1  controller has filled the victim way; one-cycle pulse.
victimReq  out  1  victimWay and victimIdx are valid and held stable.
victimWay  out  NUM_WAYS  one-hot victim way.
victimIdx  out  WAY_IDX_W  binary index of the victim way.
busy  out  1  high whenever state is not IDLE.
protocolErr  out  1  sticky flag for an illegal strobe combination; cleared only by reset.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - age[i]=i, so way 0 is MRU and way NUM_WAYS-1 is LRU.
  - All outputs are 0.
- Invariant: the ages always form a permutation of 0..NUM_WAYS-1. 0 means MRU; NUM_WAYS-1 means LRU.
- touch(w), single cycle:
  - every way j with age[j] < age[w] increments by 1;
  - age[w] becomes 0;
  - all other ages are unchanged.
- FSM has two states: IDLE and WAIT_FILL.
- IDLE:
  - hit=1, miss=0, hitWay one-hot: touch(hitWay) at that edge; state stays IDLE.
  - miss=1, hit=0: compute the victim combinationally and register it; state goes to WAIT_FILL.
    - victim = lowest-index way with wayValid=0, if any;
    - otherwise the way with age == NUM_WAYS-1.
    - victimReq, victimWay, victimIdx and busy are asserted from the next cycle (1-cycle latency).
  - hit=1 and miss=1 together: no age update, no state change, protocolErr<=1.
  - hit=1 with hitWay not one-hot (zero or multi-bit): no update, protocolErr<=1.
  - fillAck in IDLE: ignored.
- WAIT_FILL:
  - victim outputs are held stable; victimReq=1.
  - hit and miss are ignored, with no error flagged (controller is blocking).
  - fillAck=1: touch(victim); state goes to IDLE. victimReq, busy and victimWay clear on the next cycle; victimIdx is also cleared to 0.
  - A miss arriving in the same cycle as fillAck is ignored.
  - The earliest the next miss is accepted is the cycle after the return to IDLE.
- wayValid is sampled only at the miss edge; later changes do not alter the held victim.
- Reset asserted mid-WAIT_FILL: victimReq drops immediately (async) and ages reinitialise.
- No wrap-around is possible: age counters saturate by construction, because of the permutation invariant.

Decomposition:
- Shared package cache_pkg holds:
  - the state enum type (IDLE, WAIT_FILL);
  - a function for the way-index width;
  - a onehot-to-index function, shared with the lookup side.
- One natural sub-module, lru_victim_select (combinational):
  - inputs: age array and wayValid;
  - outputs: one-hot victim and victim index;
  - contains the invalid-first priority encoder and the LRU match.
- Age registers and the FSM stay in lru_eviction_policy.

Test Plan (NUM_WAYS=4):
1. Reset, wayValid=0000, miss pulse -> one cycle later victimReq=1, victimWay=0001, victimIdx=0, busy=1; fillAck -> next cycle victimReq=0, busy=0.
2. Fill all four ways: set each way's valid bit after its fill, giving victims 0,1,2,3 in order -> ages {3,2,1,0} for ways 0..3. Then a miss with wayValid=1111 -> victimWay=0001.
3. From the state in scenario 2, hit with hitWay=0001 -> ages {0,3,2,1}; then miss -> victimWay=0010, victimIdx=1.
4. hit=1 and miss=1 together -> protocolErr=1, ages unchanged, busy=0. After a reset, hit with hitWay=0011 -> protocolErr=1, ages unchanged.
5. In WAIT_FILL, drive a hit on 1000 and a second miss -> victim outputs unchanged and ages unchanged. fillAck while in IDLE -> no effect.
6. Assert rst_n=0 during WAIT_FILL -> victimReq=0 the same cycle; after release, ages {0,1,2,3}. Then fillAck followed by a miss in the next cycle -> the new victim is accepted and victimReq=1 one cycle later.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache-side types and helpers used by the lookup and replacement logic.
package cache_pkg;

    typedef enum logic {
        IDLE,
        WAIT_FILL
    } state_t;

    function automatic int unsigned way_idx_w(input int unsigned num_ways);
        return $clog2(num_ways);
    endfunction

    // Assumes at most one bit set; a zero vector maps to index 0.
    function automatic int unsigned onehot_to_idx(input logic [31:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (onehot[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/lru_victim_select.sv
// Combinational victim choice: lowest-index invalid way first, else the LRU way.
module lru_victim_select
    import cache_pkg::*;
#(
    parameter int unsigned NUM_WAYS = 4,
    localparam int unsigned WAY_IDX_W = way_idx_w(NUM_WAYS)
) (
    input  logic [WAY_IDX_W-1:0] age [NUM_WAYS],
    input  logic [NUM_WAYS-1:0]  way_valid,
    output logic [NUM_WAYS-1:0]  victim_way,
    output logic [WAY_IDX_W-1:0] victim_idx
);

    logic found_invalid;

    always_comb begin
        victim_way    = '0;
        found_invalid = 1'b0;
        for (int unsigned i = 0; i < NUM_WAYS; i++) begin
            if (!way_valid[i] && !found_invalid) begin
                victim_way[i] = 1'b1;
                found_invalid = 1'b1;
            end
        end
        // Ages are a permutation, so exactly one way holds the all-ones age.
        if (!found_invalid) begin
            for (int unsigned i = 0; i < NUM_WAYS; i++) begin
                if (age[i] == '1) victim_way[i] = 1'b1;
            end
        end
        victim_idx = WAY_IDX_W'(onehot_to_idx(32'(victim_way)));
    end

endmodule

// File: rtl/lru_eviction_policy.sv
// True-LRU replacement engine: tracks per-way ages and hands a victim to the controller on a miss.
module lru_eviction_policy
    import cache_pkg::*;
#(
    parameter int unsigned NUM_WAYS = 4,
    localparam int unsigned WAY_IDX_W = way_idx_w(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hit,
    input  logic                 miss,
    input  logic [NUM_WAYS-1:0]  hitWay,
    input  logic [NUM_WAYS-1:0]  wayValid,
    input  logic                 fillAck,
    output logic                 victimReq,
    output logic [NUM_WAYS-1:0]  victimWay,
    output logic [WAY_IDX_W-1:0] victimIdx,
    output logic                 busy,
    output logic                 protocolErr
);

    state_t               state_q, state_d;
    logic [WAY_IDX_W-1:0] age_q [NUM_WAYS];
    logic [WAY_IDX_W-1:0] age_d [NUM_WAYS];
    logic [NUM_WAYS-1:0]  victim_way_q;
    logic [WAY_IDX_W-1:0] victim_idx_q;
    logic                 err_q;

    logic [NUM_WAYS-1:0]  sel_way;
    logic [WAY_IDX_W-1:0] sel_idx;
    logic                 touch_en;
    logic [NUM_WAYS-1:0]  touch_way;
    logic [WAY_IDX_W-1:0] touch_age;
    logic                 load_victim;
    logic                 clear_victim;
    logic                 err_set;

    lru_victim_select #(
        .NUM_WAYS (NUM_WAYS)
    ) u_select (
        .age        (age_q),
        .way_valid  (wayValid),
        .victim_way (sel_way),
        .victim_idx (sel_idx)
    );

    always_comb begin
        state_d      = state_q;
        touch_en     = 1'b0;
        touch_way    = '0;
        load_victim  = 1'b0;
        clear_victim = 1'b0;
        err_set      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit && miss) begin
                    err_set = 1'b1;
                end else if (hit) begin
                    if ($onehot(hitWay)) begin
                        touch_en  = 1'b1;
                        touch_way = hitWay;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (miss) begin
                    load_victim = 1'b1;
                    state_d     = WAIT_FILL;
                end
            end
            WAIT_FILL: begin
                if (fillAck) begin
                    touch_en     = 1'b1;
                    touch_way    = victim_way_q;
                    clear_victim = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Touch: the touched way becomes MRU, every younger way ages by one.
    always_comb begin
        touch_age = '0;
        for (int unsigned i = 0; i < NUM_WAYS; i++) begin
            if (touch_way[i]) touch_age = age_q[i];
        end
        for (int unsigned j = 0; j < NUM_WAYS; j++) begin
            age_d[j] = age_q[j];
            if (touch_en) begin
                if (touch_way[j])
                    age_d[j] = '0;
                else if (age_q[j] < touch_age)
                    age_d[j] = age_q[j] + WAY_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            victim_way_q <= '0;
            victim_idx_q <= '0;
            err_q        <= 1'b0;
            for (int unsigned i = 0; i < NUM_WAYS; i++) begin
                age_q[i] <= WAY_IDX_W'(i);
            end
        end else begin
            state_q <= state_d;
            for (int unsigned i = 0; i < NUM_WAYS; i++) begin
                age_q[i] <= age_d[i];
            end
            if (load_victim) begin
                victim_way_q <= sel_way;
                victim_idx_q <= sel_idx;
            end else if (clear_victim) begin
                victim_way_q <= '0;
                victim_idx_q <= '0;
            end
            if (err_set) err_q <= 1'b1;
        end
    end

    assign victimReq   = (state_q == WAIT_FILL);
    assign busy        = (state_q == WAIT_FILL);
    assign victimWay   = victim_way_q;
    assign victimIdx   = victim_idx_q;
    assign protocolErr = err_q;

endmodule

// File: tb/tb_lru_eviction_policy.sv
// Directed self-checking bench for lru_eviction_policy with NUM_WAYS=4.
module tb_lru_eviction_policy;

    logic       clk;
    logic       rst_n;
    logic       hit;
    logic       miss;
    logic [3:0] hitWay;
    logic [3:0] wayValid;
    logic       fillAck;
    logic       victimReq;
    logic [3:0] victimWay;
    logic [1:0] victimIdx;
    logic       busy;
    logic       protocolErr;

    int n_cmp;
    int n_fail;

    lru_eviction_policy #(
        .NUM_WAYS (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hit         (hit),
        .miss        (miss),
        .hitWay      (hitWay),
        .wayValid    (wayValid),
        .fillAck     (fillAck),
        .victimReq   (victimReq),
        .victimWay   (victimWay),
        .victimIdx   (victimIdx),
        .busy        (busy),
        .protocolErr (protocolErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ages packed as {way3, way2, way1, way0}.
    function automatic logic [7:0] ages();
        return {dut.age_q[3], dut.age_q[2], dut.age_q[1], dut.age_q[0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hit = 1'b0; miss = 1'b0; hitWay = '0; fillAck = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({victimReq, victimWay, victimIdx, busy, protocolErr} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b want=0", {victimReq, victimWay, victimIdx, busy, protocolErr});
        end
        n_cmp++;
        if (ages() !== 8'b11_10_01_00) begin
            n_fail++;
            $display("FAIL reset_ages got=%b want=11100100", ages());
        end
    endtask

    task automatic test_first_miss();
        wayValid = 4'b0000;
        miss = 1'b1;
        cyc();
        miss = 1'b0;
        n_cmp++;
        if ({victimReq, busy, victimWay, victimIdx} !== {1'b1, 1'b1, 4'b0001, 2'd0}) begin
            n_fail++;
            $display("FAIL first_miss got req=%b busy=%b way=%b idx=%0d want 1 1 0001 0", victimReq, busy, victimWay, victimIdx);
        end
        fillAck = 1'b1;
        cyc();
        fillAck = 1'b0;
        n_cmp++;
        if ({victimReq, busy, victimWay, victimIdx} !== 8'b0) begin
            n_fail++;
            $display("FAIL first_fill_clear got req=%b busy=%b way=%b idx=%0d want all 0", victimReq, busy, victimWay, victimIdx);
        end
    endtask

    task automatic test_fill_all();
        logic [3:0] valid_seq [3];
        logic [3:0] exp_way [3];
        valid_seq = '{4'b0001, 4'b0011, 4'b0111};
        exp_way   = '{4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 3; i++) begin
            wayValid = valid_seq[i];
            miss = 1'b1;
            cyc();
            miss = 1'b0;
            n_cmp++;
            if (victimWay !== exp_way[i] || victimIdx !== 2'(i + 1)) begin
                n_fail++;
                $display("FAIL fill_victim_%0d got way=%b idx=%0d want way=%b idx=%0d", i + 1, victimWay, victimIdx, exp_way[i], i + 1);
            end
            fillAck = 1'b1;
            cyc();
            fillAck = 1'b0;
        end
        n_cmp++;
        if (ages() !== 8'b00_01_10_11) begin
            n_fail++;
            $display("FAIL fill_all_ages got=%b want=00011011", ages());
        end
        wayValid = 4'b1111;
        miss = 1'b1;
        cyc();
        miss = 1'b0;
        n_cmp++;
        if (victimWay !== 4'b0001 || victimIdx !== 2'd0) begin
            n_fail++;
            $display("FAIL lru_victim_full got way=%b idx=%0d want way=0001 idx=0", victimWay, victimIdx);
        end
        fillAck = 1'b1;
        cyc();
        fillAck = 1'b0;
    endtask

    task automatic test_hit_touch();
        hit = 1'b1; hitWay = 4'b0001;
        cyc();
        hit = 1'b0; hitWay = '0;
        n_cmp++;
        if (ages() !== 8'b01_10_11_00) begin
            n_fail++;
            $display("FAIL hit_way0_ages got=%b want=01101100", ages());
        end
        miss = 1'b1;
        cyc();
        miss = 1'b0;
        n_cmp++;
        if (victimWay !== 4'b0010 || victimIdx !== 2'd1) begin
            n_fail++;
            $display("FAIL victim_after_hit got way=%b idx=%0d want way=0010 idx=1", victimWay, victimIdx);
        end
        fillAck = 1'b1;
        cyc();
        fillAck = 1'b0;
        n_cmp++;
        if (ages() !== 8'b10_11_00_01) begin
            n_fail++;
            $display("FAIL touch_lru_ages got=%b want=10110001", ages());
        end
    endtask

    task automatic test_protocol_err();
        hit = 1'b1; miss = 1'b1; hitWay = 4'b0100;
        cyc();
        idle_inputs();
        n_cmp++;
        if (protocolErr !== 1'b1 || busy !== 1'b0 || ages() !== 8'b10_11_00_01) begin
            n_fail++;
            $display("FAIL hit_and_miss got err=%b busy=%b ages=%b want 1 0 10110001", protocolErr, busy, ages());
        end
        do_reset();
        n_cmp++;
        if (protocolErr !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cleared_by_reset got=%b want=0", protocolErr);
        end
        hit = 1'b1; hitWay = 4'b0011;
        cyc();
        idle_inputs();
        n_cmp++;
        if (protocolErr !== 1'b1 || ages() !== 8'b11_10_01_00) begin
            n_fail++;
            $display("FAIL multi_hot_hit got err=%b ages=%b want 1 11100100", protocolErr, ages());
        end
        do_reset();
        hit = 1'b1; hitWay = 4'b0000;
        cyc();
        idle_inputs();
        n_cmp++;
        if (protocolErr !== 1'b1 || ages() !== 8'b11_10_01_00) begin
            n_fail++;
            $display("FAIL zero_hit got err=%b ages=%b want 1 11100100", protocolErr, ages());
        end
        do_reset();
        hit = 1'b1; hitWay = 4'b0100;
        cyc();
        idle_inputs();
        n_cmp++;
        if (protocolErr !== 1'b0 || ages() !== 8'b11_00_10_01) begin
            n_fail++;
            $display("FAIL hit_way2 got err=%b ages=%b want 0 11001001", protocolErr, ages());
        end
    endtask

    task automatic test_wait_fill_ignore();
        do_reset();
        wayValid = 4'b1111;
        miss = 1'b1;
        cyc();
        miss = 1'b0;
        n_cmp++;
        if (victimWay !== 4'b1000 || victimIdx !== 2'd3) begin
            n_fail++;
            $display("FAIL victim_reset_lru got way=%b idx=%0d want way=1000 idx=3", victimWay, victimIdx);
        end
        hit = 1'b1; hitWay = 4'b1000; miss = 1'b1; wayValid = 4'b0000;
        cyc();
        cyc();
        idle_inputs();
        n_cmp++;
        if ({victimReq, victimWay, victimIdx} !== {1'b1, 4'b1000, 2'd3} || ages() !== 8'b11_10_01_00 || protocolErr !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_fill_hold got req=%b way=%b idx=%0d ages=%b err=%b want 1 1000 3 11100100 0", victimReq, victimWay, victimIdx, ages(), protocolErr);
        end
        fillAck = 1'b1;
        cyc();
        n_cmp++;
        if (ages() !== 8'b00_11_10_01 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_way3 got ages=%b busy=%b want 00111001 0", ages(), busy);
        end
        cyc();
        fillAck = 1'b0;
        n_cmp++;
        if (ages() !== 8'b00_11_10_01 || victimReq !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_fillack got ages=%b req=%b busy=%b want 00111001 0 0", ages(), victimReq, busy);
        end
    endtask

    task automatic test_back_to_back();
        wayValid = 4'b1111;
        miss = 1'b1;
        cyc();
        miss = 1'b0;
        n_cmp++;
        if (victimReq !== 1'b1 || victimWay !== 4'b0100) begin
            n_fail++;
            $display("FAIL pre_reset_victim got req=%b way=%b want 1 0100", victimReq, victimWay);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (victimReq !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_drop got req=%b busy=%b want 0 0", victimReq, busy);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        n_cmp++;
        if (ages() !== 8'b11_10_01_00) begin
            n_fail++;
            $display("FAIL ages_after_reset got=%b want=11100100", ages());
        end
        miss = 1'b1;
        cyc();
        fillAck = 1'b1;
        cyc();
        fillAck = 1'b0;
        n_cmp++;
        if (victimReq !== 1'b0 || victimIdx !== 2'd0 || ages() !== 8'b00_11_10_01) begin
            n_fail++;
            $display("FAIL miss_with_fillack got req=%b idx=%0d ages=%b want 0 0 00111001", victimReq, victimIdx, ages());
        end
        cyc();
        miss = 1'b0;
        n_cmp++;
        if ({victimReq, busy, victimWay, victimIdx} !== {1'b1, 1'b1, 4'b0100, 2'd2}) begin
            n_fail++;
            $display("FAIL next_miss_accepted got req=%b busy=%b way=%b idx=%0d want 1 1 0100 2", victimReq, busy, victimWay, victimIdx);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        wayValid = '0;
        idle_inputs();
        test_reset();
        test_first_miss();
        test_fill_all();
        test_hit_touch();
        test_protocol_err();
        test_wait_fill_ignore();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
